risc_imem_loader: RTL and testbench

- Instruction-memory stage that feeds the RISC CPU's fetch path.
- Holds a DEPTH x 13-bit program store.
- Accepts a program as a byte stream over a valid/ready load interface, low byte first.
- Holds the CPU in reset while loading, then releases it and serves instruction = mem[pc] to the instruction unit.

---
 rtl/risc_imem_loader_if.sv | 36 +++
 rtl/risc_imem_loader.sv | 163 ++++++++++++++++
 tb/tb_risc_imem_loader.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_imem_loader_if.sv
// rtl/risc_imem_loader_if.sv - load-stream and fetch-side signal bundle for risc_imem_loader
//
// Purpose: groups the byte-load handshake and the CPU fetch/status signals.
// Ports (signals):
//   ld_start, ld_vld, ld_data[7:0], ld_end : load stream, driven by the master
//   ld_rdy                                  : loader accepts bytes
//   pc[AW-1:0]                              : CPU program counter
//   instruction[12:0]                       : fetched instruction word
//   cpu_rst_n, load_done                    : CPU reset release / load complete
//   word_cnt[AW:0], ld_err                  : load progress and sticky format error
//   master modport = program source + CPU side, slave modport = loader.
interface risc_imem_loader_if #(
  parameter int AW = 5
);
  logic          ld_start;
  logic          ld_vld;
  logic [7:0]    ld_data;
  logic          ld_end;
  logic          ld_rdy;
  logic [AW-1:0] pc;
  logic [12:0]   instruction;
  logic          cpu_rst_n;
  logic          load_done;
  logic [AW:0]   word_cnt;
  logic          ld_err;

  modport master (
    output ld_start, ld_vld, ld_data, ld_end, pc,
    input  ld_rdy, instruction, cpu_rst_n, load_done, word_cnt, ld_err
  );

  modport slave (
    input  ld_start, ld_vld, ld_data, ld_end, pc,
    output ld_rdy, instruction, cpu_rst_n, load_done, word_cnt, ld_err
  );
endinterface

// File: rtl/risc_imem_loader.sv
// rtl/risc_imem_loader.sv - byte-stream program loader and instruction store for the RISC CPU
//
// Purpose: DEPTH x 13-bit instruction memory. A program arrives as bytes
// (low byte first) over the load stream; the CPU is held in reset while the
// store is cleared and loaded, then released and served mem[pc].
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : risc_imem_loader_if.slave (load stream in, fetch/status out)
module risc_imem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  risc_imem_loader_if.slave     bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LO,
    HI,
    RUN
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] waddr;
  logic [7:0]    lo_byte;
  logic [AW:0]   word_cnt;
  logic          ld_err;
  logic          ld_rdy;
  logic          cpu_rst_n;
  logic          load_done;

  logic [12:0]   mem [DEPTH];
  logic          mem_we;
  logic [12:0]   mem_wdata;

  // Memory has no reset; it is written while clearing and on each completed
  // word. An abort (ld_start) in HI must not commit the pending word.
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = 13'h0;
    if (rst_n) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (state == HI && !bus.ld_start && bus.ld_vld) begin
        mem_we    = 1'b1;
        mem_wdata = {bus.ld_data[4:0], lo_byte};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      waddr     <= '0;
      lo_byte   <= 8'h0;
      word_cnt  <= '0;
      ld_err    <= 1'b0;
      ld_rdy    <= 1'b0;
      cpu_rst_n <= 1'b0;
      load_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ld_start) begin
            state <= CLEAR;
            waddr <= '0;
          end
        end

        CLEAR: begin
          if (waddr == LAST) begin
            waddr  <= '0;
            state  <= LO;
            ld_rdy <= 1'b1;
          end else begin
            waddr <= waddr + AW'(1);
          end
        end

        LO, HI: begin
          if (bus.ld_start) begin
            // Abort: restart from a cleared store.
            state    <= CLEAR;
            waddr    <= '0;
            word_cnt <= '0;
            ld_err   <= 1'b0;
            ld_rdy   <= 1'b0;
          end else if (state == LO) begin
            if (bus.ld_end) begin
              state     <= RUN;
              ld_rdy    <= 1'b0;
              cpu_rst_n <= 1'b1;
              load_done <= 1'b1;
            end else if (bus.ld_vld) begin
              lo_byte <= bus.ld_data;
              state   <= HI;
            end
          end else begin
            if (bus.ld_vld) begin
              waddr    <= waddr + AW'(1);
              word_cnt <= word_cnt + (AW+1)'(1);
              if (bus.ld_data[7:5] != 3'b000) begin
                ld_err <= 1'b1;
              end
              // Storing the last word auto-starts the CPU.
              if (waddr == LAST || bus.ld_end) begin
                state     <= RUN;
                ld_rdy    <= 1'b0;
                cpu_rst_n <= 1'b1;
                load_done <= 1'b1;
              end else begin
                state <= LO;
              end
            end else if (bus.ld_end) begin
              // Half word is dropped.
              state     <= RUN;
              ld_rdy    <= 1'b0;
              cpu_rst_n <= 1'b1;
              load_done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (bus.ld_start) begin
            state     <= CLEAR;
            waddr     <= '0;
            word_cnt  <= '0;
            ld_err    <= 1'b0;
            cpu_rst_n <= 1'b0;
            load_done <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Fetch is only exposed once the program is complete.
  assign bus.instruction = (state == RUN && ({1'b0, bus.pc} < (AW+1)'(DEPTH)))
                           ? mem[bus.pc] : 13'h0;
  assign bus.ld_rdy      = ld_rdy;
  assign bus.cpu_rst_n   = cpu_rst_n;
  assign bus.load_done   = load_done;
  assign bus.word_cnt    = word_cnt;
  assign bus.ld_err      = ld_err;

endmodule

// File: tb/tb_risc_imem_loader.sv
// tb/tb_risc_imem_loader.sv - self-checking bench for risc_imem_loader
module tb_risc_imem_loader;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  risc_imem_loader_if #(.AW(5)) bus ();

  risc_imem_loader #(.DEPTH(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program image plus load progress flags.
  logic [12:0] m_mem [32];
  int          m_wc;
  bit          m_err;
  bit          m_run;
  bit          m_loading;
  bit          m_have_lo;
  logic [7:0]  m_lo;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [12:0] word;
    bit          err_after;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_pc(input string tag, input int p);
    bus.pc = p[4:0];
    #1;
    chk({tag, " instr"}, {19'h0, bus.instruction}, {19'h0, (m_run ? m_mem[p] : 13'h0)});
  endtask

  task automatic check_all(input string tag);
    chk({tag, " ld_rdy"}, {31'h0, bus.ld_rdy}, {31'h0, m_loading});
    chk({tag, " cpu_rst_n"}, {31'h0, bus.cpu_rst_n}, {31'h0, m_run});
    chk({tag, " load_done"}, {31'h0, bus.load_done}, {31'h0, m_run});
    chk({tag, " word_cnt"}, {26'h0, bus.word_cnt}, m_wc);
    chk({tag, " ld_err"}, {31'h0, bus.ld_err}, {31'h0, m_err});
    check_pc(tag, $urandom_range(0, 31));
  endtask

  task automatic model_run();
    m_run     = 1;
    m_loading = 0;
    m_have_lo = 0;
  endtask

  // ld_start pulse followed by the DEPTH-cycle clear; junk on the stream
  // (and a stray ld_start) during the clear must be ignored.
  task automatic start_load(input string tag);
    bus.ld_start = 1;
    bus.ld_vld   = 0;
    bus.ld_end   = 0;
    cyc();
    bus.ld_start = 0;
    m_run = 0; m_loading = 0; m_wc = 0; m_err = 0; m_have_lo = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = 13'h0;
    check_all({tag, " clr0"});
    for (int i = 1; i < 32; i++) begin
      bus.ld_vld   = 1'($urandom_range(0, 1));
      bus.ld_data  = 8'($urandom);
      bus.ld_start = (i == 10);
      cyc();
      chk({tag, " clr ld_rdy"}, {31'h0, bus.ld_rdy}, 32'h0);
      chk({tag, " clr cpu_rst_n"}, {31'h0, bus.cpu_rst_n}, 32'h0);
    end
    bus.ld_start = 0;
    cyc();
    bus.ld_vld = 0;
    m_loading  = 1;
    check_all({tag, " clr_done"});
  endtask

  task automatic send_byte(input string tag, input logic [7:0] b, input bit with_end);
    bus.ld_vld  = 1;
    bus.ld_data = b;
    bus.ld_end  = with_end;
    cyc();
    bus.ld_vld = 0;
    bus.ld_end = 0;
    if (m_loading) begin
      if (!m_have_lo) begin
        if (with_end) model_run();
        else begin
          m_lo      = b;
          m_have_lo = 1;
        end
      end else begin
        m_mem[m_wc] = {b[4:0], m_lo};
        m_wc++;
        if (b[7:5] != 3'b000) m_err = 1;
        m_have_lo = 0;
        if (m_wc == 32 || with_end) model_run();
      end
    end
    check_all(tag);
  endtask

  task automatic send_end(input string tag);
    bus.ld_end = 1;
    bus.ld_vld = 0;
    cyc();
    bus.ld_end = 0;
    if (m_loading) model_run();
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    bus.ld_vld = 0;
    bus.ld_end = 0;
    cyc();
    check_all(tag);
  endtask

  task automatic apply_vec(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      send_byte("vec lo", vt[i].lo, 0);
      send_byte("vec hi", vt[i].hi, 0);
      chk("vec ld_err", {31'h0, bus.ld_err}, {31'h0, vt[i].err_after});
    end
  endtask

  int r;

  initial begin
    tests = 0;
    fails = 0;
    vt[0] = '{8'h5C, 8'h1A, 13'h1A5C, 1'b0};
    vt[1] = '{8'h23, 8'h01, 13'h0123, 1'b0};
    vt[2] = '{8'hFF, 8'h1F, 13'h1FFF, 1'b0};
    vt[3] = '{8'h07, 8'hE3, 13'h0307, 1'b1};
    vt[4] = '{8'h00, 8'h20, 13'h0000, 1'b1};
    vt[5] = '{8'hAA, 8'h55, 13'h15AA, 1'b1};

    rst_n = 0;
    bus.ld_start = 0; bus.ld_vld = 0; bus.ld_end = 0; bus.ld_data = 0; bus.pc = 0;
    m_run = 0; m_loading = 0; m_wc = 0; m_err = 0; m_have_lo = 0; m_lo = 0;
    cyc();
    cyc();
    check_all("reset");
    rst_n = 1;
    idle("idle");

    // Three words, ld_end in LO.
    start_load("t2");
    apply_vec(0, 2);
    send_end("t2 end");
    chk("t2 word_cnt", {26'h0, bus.word_cnt}, 32'd3);
    chk("t2 load_done", {31'h0, bus.load_done}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.pc = i[4:0];
      #1;
      chk("t2 table instr", {19'h0, bus.instruction}, {19'h0, vt[i].word});
    end
    check_pc("t2 pc3", 3);

    // Bad high bytes set the sticky error.
    start_load("t4");
    apply_vec(3, 5);
    send_end("t4 end");
    for (int i = 3; i <= 5; i++) begin
      bus.pc = 5'(i - 3);
      #1;
      chk("t4 table instr", {19'h0, bus.instruction}, {19'h0, vt[i].word});
    end
    chk("t4 err sticky", {31'h0, bus.ld_err}, 32'd1);
    idle("t4 hold");

    // Full 64-byte load auto-runs; the 65th byte is ignored.
    start_load("t3");
    for (int i = 0; i < 64; i++) send_byte("t3 byte", 8'($urandom_range(0, 31) + (i % 2 == 0 ? 0 : 0)), 0);
    chk("t3 word_cnt", {26'h0, bus.word_cnt}, 32'd32);
    check_pc("t3 pc31", 31);
    send_byte("t3 extra", 8'h77, 0);
    chk("t3 extra ld_rdy", {31'h0, bus.ld_rdy}, 32'd0);

    // Partial word dropped on ld_end in HI; byte dropped on ld_end+vld in LO.
    start_load("t5");
    send_byte("t5 lo", 8'h11, 0);
    send_byte("t5 hi", 8'h01, 0);
    send_byte("t5 lo2", 8'h22, 0);
    send_end("t5 end");
    chk("t5 word_cnt", {26'h0, bus.word_cnt}, 32'd1);
    check_pc("t5 pc1", 1);
    start_load("t5b");
    send_byte("t5b lo", 8'h11, 0);
    send_byte("t5b hi", 8'h01, 0);
    send_byte("t5b drop", 8'h33, 1);
    chk("t5b word_cnt", {26'h0, bus.word_cnt}, 32'd1);
    check_pc("t5b pc1", 1);

    // Restart from RUN wipes the program.
    start_load("t6");
    send_end("t6 end");
    for (int i = 0; i < 32; i++) check_pc("t6 zero", i);

    // Reset in the middle of a word.
    start_load("t6r");
    send_byte("t6r lo", 8'h11, 0);
    rst_n = 0;
    cyc();
    rst_n = 1;
    m_run = 0; m_loading = 0; m_wc = 0; m_err = 0; m_have_lo = 0;
    check_all("t6r reset");
    send_byte("t6r idle byte", 8'h44, 0);

    // Randomized loads, aborts and early ends.
    for (int it = 0; it < 20; it++) begin
      start_load("rnd start");
      for (int k = 0; k < 90 && m_loading; k++) begin
        r = $urandom_range(0, 99);
        if (r < 70)      send_byte("rnd byte", 8'($urandom), 0);
        else if (r < 85) idle("rnd idle");
        else if (r < 89) send_end("rnd end");
        else if (r < 94) send_byte("rnd byte_end", 8'($urandom), 1);
        else if (r < 96) start_load("rnd abort");
        else             idle("rnd idle2");
      end
      if (m_loading) send_end("rnd final");
      send_byte("rnd stray", 8'($urandom), 0);
      for (int j = 0; j < 4; j++) check_pc("rnd pc", $urandom_range(0, 31));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
